// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

   // Capture FSM: SYNC waits for the first rising edge, then HIGH/LOW follow the waveform.
   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_e;

   // Generator repeat interval in clk cycles; capture timeout defaults to twice this.
   localparam int PWM_INTERVAL    = 1200;
   localparam int TIMEOUT_DEFAULT = 2 * PWM_INTERVAL;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pad input, with rise/fall detection
// on the synchronised level. Edge flags are valid for exactly one clk cycle.
module sync_edge
   import pwm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   // Synchroniser chain plus one extra stage holding the previous synchronised level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~dly_q;
   assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: high time and period in clk cycles, reported
// once per PWM cycle on a single-cycle valid strobe. A line with no rising edge for
// TIMEOUT cycles is reported as stuck, with high_time showing the static level.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter  int TIMEOUT = TIMEOUT_DEFAULT,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm_in,
   output logic [CW-1:0] high_time,
   output logic [CW-1:0] period,
   output logic          valid,
   output logic          stuck
);

   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   logic          pwm_s;
   logic          rise;
   logic          fall;
   logic          timeout;

   pwm_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] hi_cnt_q;
   logic [CW-1:0] high_time_q;
   logic [CW-1:0] period_q;
   logic          valid_q;
   logic          stuck_q;

   sync_edge u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .async_i (pwm_in),
      .level_o (pwm_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // A rise in the same cycle as the counter saturating is a real edge, not a timeout.
   assign timeout = (cnt_q == TIMEOUT_C) && !rise;

   // Cycle counter: the rise cycle counts as cycle 1 of the new period; saturates at
   // TIMEOUT and restarts from 0 after a timeout so stuck reports repeat every TIMEOUT+1.
   always_comb begin
      cnt_d = cnt_q;
      if (rise) begin
         cnt_d = ONE_C;
      end else if (timeout) begin
         cnt_d = '0;
      end else if (cnt_q != TIMEOUT_C) begin
         cnt_d = cnt_q + ONE_C;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Measurement FSM with registered report outputs; timeout overrides every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SYNC;
         hi_cnt_q    <= '0;
         high_time_q <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (timeout) begin
            state_q     <= SYNC;
            period_q    <= TIMEOUT_C;
            high_time_q <= pwm_s ? TIMEOUT_C : '0;
            stuck_q     <= 1'b1;
            valid_q     <= 1'b1;
         end else begin
            case (state_q)
               // Partial first period is discarded: just align to a rising edge.
               SYNC: begin
                  if (rise) begin
                     state_q <= HIGH;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state_q  <= LOW;
                     hi_cnt_q <= cnt_q;
                  end
               end
               LOW: begin
                  if (rise) begin
                     state_q     <= HIGH;
                     period_q    <= cnt_q;
                     high_time_q <= hi_cnt_q;
                     stuck_q     <= 1'b0;
                     valid_q     <= 1'b1;
                  end
               end
               default: begin
                  state_q <= SYNC;
               end
            endcase
         end
      end
   end

   assign high_time = high_time_q;
   assign period    = period_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;

endmodule
